// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter and fetch-control stage feeding the instruction memory.
//   Holds the PC and selects the next PC from PC+4, a PC-relative target or
//   a JALR target. A three-state FSM (BOOT/RUN/HALT) gives one settle cycle
//   after reset and traps misaligned targets and halt requests.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   en          in   advance enable (0 = stall)
//   PCSrc       in   next-PC select: 00 PC+4, 01 PC+ImmExt, 10 JALR, 11 halt
//   ImmExt      in   sign-extended immediate for PC-relative target
//   ALUResult   in   rs1+imm from the ALU, JALR target before bit-0 clear
//   PC          out  current PC (instruction memory address)
//   PCPlus4     out  PC+4, combinational
//   PCTarget    out  PC+ImmExt, combinational
//   fetch_valid out  current fetch is architecturally valid
//   halted      out  unit is in HALT
//   fault_code  out  00 none, 01 misaligned branch, 10 misaligned JALR, 11 halt
//   fault_pc    out  PC of the instruction that caused the halt
//   fetch_cnt   out  wrapping count of valid advanced fetches
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       PCSrc,
    input  logic [31:0]      ImmExt,
    input  logic [31:0]      ALUResult,
    output logic [31:0]      PC,
    output logic [31:0]      PCPlus4,
    output logic [31:0]      PCTarget,
    output logic             fetch_valid,
    output logic             halted,
    output logic [1:0]       fault_code,
    output logic [31:0]      fault_pc,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [1:0]       fault_code_q, fault_code_d;
    logic [31:0]      fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             halted_q, halted_d;

    logic [31:0] pc_plus4;
    logic [31:0] pc_target;
    logic [31:0] jalr_target;

    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        pc_target   = pc_q + ImmExt;
        jalr_target = {ALUResult[31:1], 1'b0};
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fault_code_d = fault_code_q;
        fault_pc_d   = fault_pc_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (en) begin
                    // Every enabled RUN edge counts, including the one that traps.
                    cnt_d = cnt_q + CNT_ONE;
                    unique case (PCSrc)
                        2'b00: pc_d = pc_plus4;
                        2'b01: begin
                            if (pc_target[1:0] == 2'b00) begin
                                pc_d = pc_target;
                            end else begin
                                state_d      = S_HALT;
                                fault_code_d = 2'b01;
                                fault_pc_d   = pc_q;
                            end
                        end
                        2'b10: begin
                            if (jalr_target[1:0] == 2'b00) begin
                                pc_d = jalr_target;
                            end else begin
                                state_d      = S_HALT;
                                fault_code_d = 2'b10;
                                fault_pc_d   = pc_q;
                            end
                        end
                        default: begin
                            state_d      = S_HALT;
                            fault_code_d = 2'b11;
                            fault_pc_d   = pc_q;
                        end
                    endcase
                end
            end
            default: state_d = S_HALT;
        endcase

        // Status flags are registered alongside the state they describe.
        valid_d  = (state_d == S_RUN);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= RESET_VECTOR;
            fault_code_q <= '0;
            fault_pc_q   <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fault_code_q <= fault_code_d;
            fault_pc_q   <= fault_pc_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            halted_q     <= halted_d;
        end
    end

    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign PCTarget    = pc_target;
    assign fetch_valid = valid_q;
    assign halted      = halted_q;
    assign fault_code  = fault_code_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_cnt   = cnt_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and fetch-control stage directly upstream of the instruction memory.
- Holds the PC, drives the memory address each cycle, and selects the next PC from PC+4, PC-relative target, or JALR target.
- Catches misaligned targets and halt requests through a small state machine.
- Provides a wrapping fetch counter for debug and performance.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of fetch counter fetch_cnt.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; 0 = stall, hold PC and all state.
- PCSrc  input  2  next-PC select: 00 PC+4, 01 PC+ImmExt (branch/JAL), 10 JALR, 11 halt request.
- ImmExt  input  32  sign-extended immediate for PC-relative target.
- ALUResult  input  32  rs1+imm from ALU for JALR target.
- PC  output  32  current PC; drives instruction memory address A.
- PCPlus4  output  32  PC+4, combinational, for the writeback mux.
- PCTarget  output  32  PC+ImmExt, combinational.
- fetch_valid  output  1  PC/instruction this cycle is architecturally valid.
- halted  output  1  unit is in HALT.
- fault_code  output  2  00 none, 01 misaligned PC-relative target, 10 misaligned JALR target, 11 halt request.
- fault_pc  output  32  PC of the instruction that caused the halt.
- fetch_cnt  output  CNT_W  count of valid advanced fetches.

Behaviour:
- Reset, when rst=1 at a clock edge, overrides all other inputs:
  - PC=RESET_VECTOR, state=BOOT.
  - fetch_valid=0, halted=0, fault_code=00, fault_pc=0, fetch_cnt=0.
- Arithmetic is 32-bit modulo; PC+4 and PC+ImmExt wrap silently.
- JALR target = {ALUResult[31:1],1'b0}, i.e. bit 0 cleared.
- Misaligned means target[1:0] != 2'b00, checked after the JALR bit-0 clear.
- State BOOT:
  - fetch_valid=0, PC held at RESET_VECTOR.
  - Next edge goes to RUN unconditionally, ignoring en and PCSrc.
  - Gives one settle cycle after reset release.
- State RUN:
  - fetch_valid=1.
  - en=0: PC, counter and state held. PCSrc is not evaluated, so no fault is possible while stalled.
  - en=1, PCSrc=00: PC<=PC+4.
  - en=1, PCSrc=01: if PCTarget aligned, PC<=PCTarget; else go to HALT, fault_code<=01.
  - en=1, PCSrc=10: if JALR target aligned, PC<=target; else go to HALT, fault_code<=10.
  - en=1, PCSrc=11: go to HALT, fault_code<=11.
  - On any entry to HALT: fault_pc<=PC and PC is held (not updated).
  - fetch_cnt increments by 1 on every edge with state=RUN and en=1, including the edge that enters HALT. It wraps from all-ones to 0.
- State HALT:
  - fetch_valid=0, halted=1.
  - PC, fault_code, fault_pc and fetch_cnt frozen.
  - en and PCSrc are ignored. The only exit is rst, which goes to BOOT.
- Latency: a next-PC selection made in cycle N appears on PC in cycle N+1. PCPlus4 and PCTarget are combinational from the current PC and ImmExt.
- Reset mid-operation (any state, including a stall or a pending fault) takes effect at that edge. The faulting transition is discarded.

Test Plan:
- Reset release, RESET_VECTOR=0: cycle 0 BOOT with PC=0, fetch_valid=0. Then 3 cycles PCSrc=00, en=1 -> PC 0,4,8,C; fetch_cnt=3; PCPlus4=0x10 when PC=0xC.
- Branch: PC=0x10, PCSrc=01, ImmExt=0xFFFFFFF8 -> next PC=0x08. With ImmExt=0x6 -> HALT, fault_code=01, fault_pc=0x10, PC stays 0x10, halted=1.
- JALR: ALUResult=0x101 -> PC=0x100 (bit 0 cleared). ALUResult=0x102 -> HALT, fault_code=10.
- Stall: en=0 for 4 cycles with PCSrc=01 and ImmExt=0x3 -> PC, fetch_cnt unchanged, no fault. en=1 then faults on the next edge.
- Halt request: PCSrc=11 at PC=0x20 -> halted=1, fault_code=11, fault_pc=0x20. Further PCSrc/en activity has no effect. rst=1 for one cycle -> BOOT, PC=RESET_VECTOR, all fault outputs cleared.
- Wrap: CNT_W=4, 16 advancing cycles -> fetch_cnt returns to 0. PC=0xFFFFFFFC with PCSrc=00 -> PC=0x00000000.
